// File: rtl/neuron_o_seq.sv
// Sequencer that time-multiplexes one pipelined neuron_o datapath across N_OUT
// output neurons of a 2-input layer, with a loadable weight file and a result stream.
module neuron_o_seq #(
  parameter int WIDTH  = 32,
  parameter int N_OUT  = 4,
  parameter int LAT    = 2,
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [WIDTH-1:0]  cfg_data,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a1,
  input  logic [WIDTH-1:0]  in_a2,
  output logic [WIDTH-1:0]  n_a1,
  output logic [WIDTH-1:0]  n_a2,
  output logic [WIDTH-1:0]  n_w1,
  output logic [WIDTH-1:0]  n_w2,
  output logic [WIDTH-1:0]  n_b,
  output logic              n_en,
  input  logic [WIDTH-1:0]  n_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_idx,
  output logic [WIDTH-1:0]  out_y,
  output logic              busy
);

  localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int TW = $clog2(N_OUT + LAT + 1);
  localparam logic [IW-1:0]   LAST_IDX  = IW'(N_OUT - 1);
  localparam logic [TW-1:0]   LAT_T     = TW'(LAT);
  localparam logic [ADDR_W:0] CFG_LIMIT = (ADDR_W + 1)'(3 * N_OUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    i_q, i_d;   // issue index
  logic [IW-1:0]    c_q, c_d;   // capture index
  logic [IW-1:0]    j_q, j_d;   // output index
  logic [TW-1:0]    t_q, t_d;   // cycles since first issue
  logic [WIDTH-1:0] a1_q, a1_d, a2_q, a2_d;
  logic             cfg_err_q, cfg_err_d;
  logic [WIDTH-1:0] w1_q  [N_OUT];
  logic [WIDTH-1:0] w1_d  [N_OUT];
  logic [WIDTH-1:0] w2_q  [N_OUT];
  logic [WIDTH-1:0] w2_d  [N_OUT];
  logic [WIDTH-1:0] b_q   [N_OUT];
  logic [WIDTH-1:0] b_d   [N_OUT];
  logic [WIDTH-1:0] res_q [N_OUT];
  logic [WIDTH-1:0] res_d [N_OUT];
  logic             cfg_reject;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    i_d       = i_q;
    c_d       = c_q;
    j_d       = j_q;
    t_d       = t_q;
    a1_d      = a1_q;
    a2_d      = a2_q;
    w1_d      = w1_q;
    w2_d      = w2_q;
    b_d       = b_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    n_en      = 1'b0;
    n_a1      = '0;
    n_a2      = '0;
    n_w1      = '0;
    n_w2      = '0;
    n_b       = '0;

    cfg_reject = cfg_we && ((state_q != S_IDLE) || ({1'b0, cfg_addr} >= CFG_LIMIT));
    cfg_err_d  = cfg_reject;
    if (cfg_we && !cfg_reject) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (cfg_addr == ADDR_W'(3 * k))     w1_d[k] = cfg_data;
        if (cfg_addr == ADDR_W'(3 * k + 1)) w2_d[k] = cfg_data;
        if (cfg_addr == ADDR_W'(3 * k + 2)) b_d[k]  = cfg_data;
      end
    end

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a1_d    = in_a1;
          a2_d    = in_a2;
          i_d     = '0;
          c_d     = '0;
          t_d     = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE, S_DRAIN: begin
        // i parks on the last neuron, so DRAIN simply holds the final operands.
        n_en = 1'b1;
        n_a1 = a1_q;
        n_a2 = a2_q;
        n_w1 = w1_q[i_q];
        n_w2 = w2_q[i_q];
        n_b  = b_q[i_q];
        t_d  = t_q + 1'b1;
        if (state_q == S_ISSUE) begin
          if (i_q == LAST_IDX) state_d = S_DRAIN;
          else                 i_d     = i_q + 1'b1;
        end
        if (t_q >= LAT_T) begin
          res_d[c_q] = n_y;
          if (c_q == LAST_IDX) state_d = S_OUT;
          else                 c_d     = c_q + 1'b1;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (j_q == LAST_IDX) begin
            j_d     = '0;
            state_d = S_IDLE;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign cfg_err = cfg_err_q;
  assign out_idx = 4'(j_q);
  assign out_y   = res_q[j_q];

  // NOTE: state updates use non-blocking assignment so all flops sample pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      c_q       <= '0;
      j_q       <= '0;
      t_q       <= '0;
      a1_q      <= '0;
      a2_q      <= '0;
      cfg_err_q <= 1'b0;
      // NOTE: the weight file and result buffer are register arrays, cleared so a reset
      // leaves neither stale weights nor stale results behind.
      for (int k = 0; k < N_OUT; k++) begin
        w1_q[k]  <= '0;
        w2_q[k]  <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      c_q       <= c_d;
      j_q       <= j_d;
      t_q       <= t_d;
      a1_q      <= a1_d;
      a2_q      <= a2_d;
      cfg_err_q <= cfg_err_d;
      w1_q      <= w1_d;
      w2_q      <= w2_d;
      b_q       <= b_d;
      res_q     <= res_d;
    end
  end

endmodule

// File: tb/tb_neuron_o_seq.sv
// Directed bench for neuron_o_seq; a two-stage Q8.24 multiply-accumulate stub stands in
// for neuron_o (tanh(0)=0 cases coincide with the stub's plain sum).
module tb_neuron_o_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_err;
  logic        in_valid, in_ready;
  logic [31:0] in_a1, in_a2;
  logic [31:0] n_a1, n_a2, n_w1, n_w2, n_b, n_y;
  logic        n_en;
  logic        out_valid, out_ready;
  logic [3:0]  out_idx;
  logic [31:0] out_y;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  neuron_o_seq #(.WIDTH(32), .N_OUT(4), .LAT(2), .ADDR_W(6)) dut (
    .clock(clock), .reset(reset),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_a1(in_a1), .in_a2(in_a2),
    .n_a1(n_a1), .n_a2(n_a2), .n_w1(n_w1), .n_w2(n_w2), .n_b(n_b), .n_en(n_en),
    .n_y(n_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_y(out_y),
    .busy(busy)
  );

  // Stub neuron: y = a1*w1 + a2*w2 + b in Q8.24, two enabled register stages.
  function automatic logic [31:0] mac(input logic [31:0] a1, a2, w1, w2, b);
    logic signed [63:0] p1, p2, s;
    p1 = $signed(a1) * $signed(w1);
    p2 = $signed(a2) * $signed(w2);
    s  = (p1 >>> 24) + (p2 >>> 24) + 64'($signed(b));
    return s[31:0];
  endfunction

  logic [31:0] stage1;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage1 <= '0;
      n_y    <= '0;
    end else if (n_en) begin
      stage1 <= mac(n_a1, n_a2, n_w1, n_w2, n_b);
      n_y    <= stage1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg_write(input logic [5:0] addr, input logic [31:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic start_txn(input logic [31:0] a1, input logic [31:0] a2);
    in_a1 = a1; in_a2 = a2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Counts cycles with the accept cycle as 1; bounded so a stuck DUT still finishes.
  task automatic wait_valid(input int start, output int cyc);
    cyc = start;
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
    end
  endtask

  task automatic collect(input string tag, input logic [31:0] e [4]);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_idx"}, 32'(out_idx), 32'(k));
      check({tag, "_y"}, out_y, e[k]);
      step();
    end
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  logic [31:0] exp_one  [4];
  logic [31:0] exp_two  [4];
  logic [31:0] exp_mix  [4];
  logic [31:0] exp_zero [4];
  int cyc, hs, n;

  initial begin
    exp_one  = '{32'h0100_0000, 32'h0100_0001, 32'h0100_0002, 32'h0100_0003};
    exp_two  = '{32'h0200_0000, 32'h0200_0001, 32'h0200_0002, 32'h0200_0003};
    exp_mix  = '{32'h0300_0000, 32'h0100_0001, 32'h0100_0002, 32'h0100_0003};
    exp_zero = '{32'h0, 32'h0, 32'h0, 32'h0};
    reset = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_a1 = '0; in_a2 = '0; out_ready = 1'b1;
    repeat (2) step();

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_n_en", 32'(n_en), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_y", out_y, 32'd0);
    check("rst_n_w1", n_w1, 32'd0);
    reset = 1'b1;
    step();

    // Load the weight file
    for (int k = 0; k < 4; k++) begin
      cfg_write(6'(3 * k), 32'h0100_0000 + 32'(k));
      cfg_write(6'(3 * k + 1), 32'h0080_0000);
      cfg_write(6'(3 * k + 2), 32'h0);
    end
    check("cfg_ok_no_err", 32'(cfg_err), 32'd0);

    // Transaction 1: weight readback during ISSUE, latency, results
    start_txn(32'h0100_0000, 32'h0);
    cyc = 1;
    for (int k = 0; k < 4; k++) begin
      check("issue_n_en", 32'(n_en), 32'd1);
      check("issue_n_w1", n_w1, 32'h0100_0000 + 32'(k));
      check("issue_n_w2", n_w2, 32'h0080_0000);
      check("issue_n_b", n_b, 32'h0);
      check("issue_n_a1", n_a1, 32'h0100_0000);
      check("issue_in_ready", 32'(in_ready), 32'd0);
      step();
      cyc++;
    end
    check("drain_n_en", 32'(n_en), 32'd1);
    check("drain_out_valid", 32'(out_valid), 32'd0);
    wait_valid(cyc, cyc);
    check("txn1_latency", 32'(cyc), 32'd7);
    collect("txn1", exp_one);

    // Transaction 2: backpressure with out_ready pattern 1,0,0,1,...
    start_txn(32'h0100_0000, 32'h0200_0000);
    wait_valid(1, cyc);
    check("txn2_latency", 32'(cyc), 32'd7);
    hs = 0; n = 0;
    while (hs < 4 && n < 40) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_idx", 32'(out_idx), 32'(hs));
      check("bp_y", out_y, exp_two[hs]);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      out_ready = (n % 3 == 0);
      step();
      if (out_ready) hs++;
      n++;
    end
    out_ready = 1'b1;
    check("bp_cycles", 32'(n), 32'd10);
    check("bp_in_ready_after", 32'(in_ready), 32'd1);
    check("bp_valid_after", 32'(out_valid), 32'd0);
    step();
    check("bp_no_extra", 32'(out_valid), 32'd0);

    // Transaction 3: config write while busy is rejected
    start_txn(32'h0100_0000, 32'h0);
    step();
    step();
    cfg_we = 1'b1; cfg_addr = 6'd0; cfg_data = 32'h7F00_0000;
    check("busy_issue", 32'(busy), 32'd1);
    step();
    cfg_we = 1'b0;
    check("busy_cfg_err", 32'(cfg_err), 32'd1);
    step();
    check("busy_cfg_err_pulse", 32'(cfg_err), 32'd0);
    wait_valid(5, cyc);
    check("txn3_latency", 32'(cyc), 32'd7);
    collect("txn3", exp_one);

    // Out-of-range address in IDLE
    cfg_write(6'd12, 32'h5555_5555);
    check("addr12_cfg_err", 32'(cfg_err), 32'd1);
    step();
    check("addr12_cfg_err_pulse", 32'(cfg_err), 32'd0);

    // Config write and accept on the same IDLE edge: new w1[0] is used
    cfg_we = 1'b1; cfg_addr = 6'd0; cfg_data = 32'h0300_0000;
    start_txn(32'h0100_0000, 32'h0);
    cfg_we = 1'b0;
    check("same_edge_cfg_err", 32'(cfg_err), 32'd0);
    check("same_edge_busy", 32'(busy), 32'd1);
    wait_valid(1, cyc);
    collect("same_edge", exp_mix);

    // Reset asserted during DRAIN
    start_txn(32'h0100_0000, 32'h0);
    repeat (4) step();
    check("pre_rst_drain_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_n_en", 32'(n_en), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (8) step();
    check("midrst_no_results", 32'(out_valid), 32'd0);
    start_txn(32'h0100_0000, 32'h0100_0000);
    check("midrst_w1_cleared", n_w1, 32'h0);
    check("midrst_w2_cleared", n_w2, 32'h0);
    check("midrst_b_cleared", n_b, 32'h0);
    check("midrst_n_a1", n_a1, 32'h0100_0000);
    wait_valid(1, cyc);
    check("midrst_latency", 32'(cyc), 32'd7);
    collect("midrst", exp_zero);

    // Back-to-back in_valid: held high, accepted only in IDLE
    in_a1 = 32'h0100_0000; in_a2 = 32'h0100_0000; in_valid = 1'b1;
    step();
    in_a1 = 32'h7F00_0000;
    check("b2b_in_ready_busy", 32'(in_ready), 32'd0);
    check("b2b_n_a1_first", n_a1, 32'h0100_0000);
    wait_valid(1, cyc);
    check("b2b_latency", 32'(cyc), 32'd7);
    collect("b2b_first", exp_zero);
    step();
    in_valid = 1'b0;
    check("b2b_second_busy", 32'(busy), 32'd1);
    check("b2b_second_in_ready", 32'(in_ready), 32'd0);
    check("b2b_n_a1_second", n_a1, 32'h7F00_0000);
    wait_valid(1, cyc);
    collect("b2b_second", exp_zero);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
